// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: N-port arbiter with run-time fixed-priority / round-robin
// selection. The winner is registered and held until the valid/ready grant
// handshake completes.
module rr_hold_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode_i,
  input  logic [N-1:0]         req_i,
  output logic                 gnt_vld_o,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  input  logic                 gnt_rdy_i
);

  localparam int unsigned IDW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_vld_q, gnt_vld_d;

  logic [N-1:0]   mask_c;
  logic [N-1:0]   req_masked_c;
  logic [N-1:0]   win_c;
  logic [IDW-1:0] win_id_c;
  logic           hs_c;

  // Lowest-index set bit, as a one-hot vector (v & -v).
  function automatic logic [N-1:0] find_first(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  // One-hot (or zero) to binary index.
  function automatic logic [IDW-1:0] onehot_to_id(input logic [N-1:0] oh);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) id = id | IDW'(i);
    end
    return id;
  endfunction

  assign hs_c = (state_q == GRANT) && gnt_rdy_i;

  // Pointer advances past the accepted winner on a round-robin handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (hs_c && mode_i) begin
      ptr_d = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
    end
  end

  // Winner selection using the already-updated pointer so back-to-back grants rotate.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < N; i++) begin
      mask_c[i] = (IDW'(i) >= ptr_d);
    end
    req_masked_c = req_i & mask_c;
    if (!mode_i) begin
      win_c = find_first(req_i);
    end else if (|req_masked_c) begin
      win_c = find_first(req_masked_c);
    end else begin
      win_c = find_first(req_i);
    end
    win_id_c = onehot_to_id(win_c);
  end

  // Next state and next grant: arbitrate in IDLE or on a handshake, otherwise hold.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = GRANT;
          gnt_d     = win_c;
          gnt_id_d  = win_id_c;
          gnt_vld_d = 1'b1;
        end
      end
      GRANT: begin
        if (gnt_rdy_i) begin
          if (|req_i) begin
            state_d   = GRANT;
            gnt_d     = win_c;
            gnt_id_d  = win_id_c;
            gnt_vld_d = 1'b1;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
          end
        end
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt_vld_o = gnt_vld_q;
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter with N = 4.
module tb_rr_hold_arbiter;

  localparam int unsigned N = 4;

  logic       clk;
  logic       reset_n;
  logic       mode_i;
  logic [3:0] req_i;
  logic       gnt_vld_o;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_rdy_i;

  int total;
  int bad;

  rr_hold_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode_i    (mode_i),
    .req_i     (req_i),
    .gnt_vld_o (gnt_vld_o),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .gnt_rdy_i (gnt_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_g(input string tag, input logic v, input logic [3:0] g,
                          input logic [1:0] id);
    total++;
    assert (gnt_vld_o === v) else begin
      bad++;
      $error("FAIL %s vld observed=%0b expected=%0b", tag, gnt_vld_o, v);
    end
    total++;
    assert (gnt_o === g) else begin
      bad++;
      $error("FAIL %s gnt observed=%0h expected=%0h", tag, gnt_o, g);
    end
    total++;
    assert (gnt_id_o === id) else begin
      bad++;
      $error("FAIL %s id observed=%0d expected=%0d", tag, gnt_id_o, id);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n   = 1'b0;
    mode_i    = 1'b0;
    req_i     = 4'h0;
    gnt_rdy_i = 1'b0;

    // Reset held, then released with no requests.
    step(); step();
    expect_g("rst_hold", 1'b0, 4'h0, 2'd0);
    reset_n = 1'b1;
    step(); expect_g("rst_rel0", 1'b0, 4'h0, 2'd0);
    step(); expect_g("rst_rel1", 1'b0, 4'h0, 2'd0);

    // Fixed priority, req 0xE, always ready: port 1 every cycle.
    mode_i = 1'b0; req_i = 4'hE; gnt_rdy_i = 1'b1;
    step(); expect_g("fix_c1", 1'b1, 4'h2, 2'd1);
    step(); expect_g("fix_c2", 1'b1, 4'h2, 2'd1);
    step(); expect_g("fix_c3", 1'b1, 4'h2, 2'd1);

    // Requests drop: grant accepted, return to idle.
    req_i = 4'h0;
    step(); expect_g("to_idle", 1'b0, 4'h0, 2'd0);

    // Round robin, all requesting: 1,2,4,8,1 (ptr untouched by fixed mode).
    mode_i = 1'b1; req_i = 4'hF;
    step(); expect_g("rr_0", 1'b1, 4'h1, 2'd0);
    step(); expect_g("rr_1", 1'b1, 4'h2, 2'd1);
    step(); expect_g("rr_2", 1'b1, 4'h4, 2'd2);
    step(); expect_g("rr_3", 1'b1, 4'h8, 2'd3);
    step(); expect_g("rr_wrap", 1'b1, 4'h1, 2'd0);
    step(); expect_g("rr_1b", 1'b1, 4'h2, 2'd1);
    step(); expect_g("rr_2b", 1'b1, 4'h4, 2'd2);

    // Hold 0x4 under backpressure while requests and mode change.
    gnt_rdy_i = 1'b0; req_i = 4'h1;
    step(); expect_g("hold_0", 1'b1, 4'h4, 2'd2);
    mode_i = 1'b0;
    step(); expect_g("hold_1", 1'b1, 4'h4, 2'd2);
    mode_i = 1'b1;
    step(); expect_g("hold_2", 1'b1, 4'h4, 2'd2);
    gnt_rdy_i = 1'b1;
    step(); expect_g("hold_rel", 1'b1, 4'h1, 2'd0);

    // Grant 0x8 then accept it: pointer wraps to 0, req 0x9 gives 1 then 8.
    req_i = 4'h8;
    step(); expect_g("wrap_g8", 1'b1, 4'h8, 2'd3);
    req_i = 4'h9;
    step(); expect_g("wrap_g1", 1'b1, 4'h1, 2'd0);
    step(); expect_g("wrap_g8b", 1'b1, 4'h8, 2'd3);

    // Build a held grant 0x2 with ptr = 2, then reset mid-grant.
    req_i = 4'h2;
    step(); expect_g("pre_g2a", 1'b1, 4'h2, 2'd1);
    step(); expect_g("pre_g2b", 1'b1, 4'h2, 2'd1);
    gnt_rdy_i = 1'b0;
    step(); expect_g("g2_held", 1'b1, 4'h2, 2'd1);
    reset_n = 1'b0;
    step(); expect_g("mid_rst", 1'b0, 4'h0, 2'd0);
    reset_n = 1'b1; req_i = 4'hF; gnt_rdy_i = 1'b1;
    step(); expect_g("post_rst", 1'b1, 4'h1, 2'd0);
    step(); expect_g("post_rst2", 1'b1, 4'h2, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
